// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the execute stage.
// Handles MULT/MULTU (shift-add, one multiplier bit per cycle) and
// DIV/DIVU (restoring division, one quotient bit per cycle).
// Signed operations run on magnitudes and fix the signs on entry to DONE.
// The unit holds the execute stage through stallE while it is busy.
// Optional build macro: MULDIV_FAST_MUL_EN replaces the iterative multiply
// with a single-cycle combinational product registered on the accept edge.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flushE,
  output logic             stallE,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Iteration counter, loaded with WIDTH-1 and counted down to zero
  logic [CW-1:0] cnt_q, cnt_d;

  // Multiplicand magnitude (MUL) or divisor magnitude (DIV)
  logic [WIDTH-1:0] opnd_q, opnd_d;

  // MUL: {partial product, remaining multiplier bits}
  // DIV: low half holds dividend bits shifting out / quotient bits shifting in
  logic [2*WIDTH-1:0] work_q, work_d;

  // Partial remainder of the restoring divide
  logic [WIDTH-1:0] rem_q, rem_d;

  // Result signs captured at accept time
  logic neg_lo_q, neg_lo_d;
  logic neg_hi_q, neg_hi_d;

  // Registered outputs
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Operand decode
  logic             signed_op;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             divzero_start;
  logic             accept;

  assign signed_op     = ~opE[0];
  assign is_div        = opE[1];
  assign sign_a        = signed_op & srcaE[WIDTH-1];
  assign sign_b        = signed_op & srcbE[WIDTH-1];
  assign abs_a         = sign_a ? -srcaE : srcaE;
  assign abs_b         = sign_b ? -srcbE : srcbE;
  assign divzero_start = is_div & (srcbE == '0);
  assign accept        = (state_q == IDLE) & startE & ~flushE;

  // One shift-add multiply step: add the multiplicand when the current
  // multiplier bit is set, then shift the whole work register right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_fix;

  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
                    (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};
  assign mul_fix  = neg_lo_q ? -mul_next : mul_next;

  // One restoring divide step on a WIDTH+1 bit shifted remainder; the
  // borrow out of the trial subtraction decides the quotient bit.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;

  assign div_shift = {rem_q, work_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {work_q[WIDTH-2:0], div_ge};
  assign rem_fix   = neg_hi_q ? -rem_next : rem_next;
  assign quo_fix   = neg_lo_q ? -quo_next : quo_next;

`ifdef MULDIV_FAST_MUL_EN
  // Full-width product of the sign- or zero-extended operands; truncating
  // to 2*WIDTH bits gives the right answer for both MULT and MULTU.
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] fast_prod;

  assign ext_a     = {{WIDTH{sign_a}}, srcaE};
  assign ext_b     = {{WIDTH{sign_b}}, srcbE};
  assign fast_prod = ext_a * ext_b;
`endif

  // Next-state and datapath update for the IDLE/MUL/DIV/DONE sequence
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    work_d   = work_q;
    rem_d    = rem_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d    = CW'(WIDTH - 1);
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = sign_a;
          if (divzero_start) begin
            state_d = DONE;
            hi_d    = srcaE;
            lo_d    = '1;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else if (is_div) begin
            state_d = DIV;
            opnd_d  = abs_b;
            work_d  = {{WIDTH{1'b0}}, abs_a};
            rem_d   = '0;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            state_d = DONE;
            hi_d    = fast_prod[2*WIDTH-1:WIDTH];
            lo_d    = fast_prod[WIDTH-1:0];
            dz_d    = 1'b0;
            done_d  = 1'b1;
`else
            state_d = MUL;
            opnd_d  = abs_a;
            work_d  = {{WIDTH{1'b0}}, abs_b};
`endif
          end
        end
      end

      MUL: begin
        if (flushE) begin
          state_d = IDLE;
        end else begin
          work_d = mul_next;
          if (cnt_q == '0) begin
            state_d = DONE;
            hi_d    = mul_fix[2*WIDTH-1:WIDTH];
            lo_d    = mul_fix[WIDTH-1:0];
            dz_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      DIV: begin
        if (flushE) begin
          state_d = IDLE;
        end else begin
          rem_d  = rem_next;
          work_d = {work_q[2*WIDTH-1:WIDTH], quo_next};
          if (cnt_q == '0) begin
            state_d = DONE;
            hi_d    = rem_fix;
            lo_d    = quo_fix;
            dz_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  // Stall while busy or while accepting an operation that will iterate;
  // a divide by zero and the DONE state let the pipeline advance.
  assign stallE   = ~rst & ((accept & ~divzero_start) |
                            (state_q == MUL) | (state_q == DIV));
  assign done     = done_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign div_zero = dz_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the execute stage of the pipelined MIPS core; successor to the single-cycle HI/LO path.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and holds the execute stage with stallE while busy.
- Cancels on flushE and presents 2×WIDTH results as hi_o/lo_o with a one-cycle done pulse for the HI/LO register write.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits, split hi_o = upper WIDTH, lo_o = lower WIDTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
startE  input  1  mul/div instruction present in execute stage
opE  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srcaE  input  WIDTH  rs operand (multiplicand / dividend)
srcbE  input  WIDTH  rt operand (multiplier / divisor)
flushE  input  1  execute-stage flush; cancels a start or an in-flight operation
stallE  output  1  hold execute stage and earlier stages
done  output  1  one-cycle pulse; hi_o/lo_o valid, write HI/LO
hi_o  output  WIDTH  HI result (product high / remainder)
lo_o  output  WIDTH  LO result (product low / quotient)
div_zero  output  1  set with done when a divide had srcbE == 0

Behaviour:
- Reset (rst=1 at a rising edge):
  - state = IDLE, counter = 0, hi_o = 0, lo_o = 0, done = 0, div_zero = 0.
  - stallE is forced to 0 while rst = 1.
  - Reset overrides any operation in progress.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If startE=1 and flushE=0, latch operands and opE, set counter = WIDTH-1, and go to MUL (op 0x) or DIV (op 1x).
  - A divide with srcbE == 0 goes directly to DONE with hi_o = srcaE, lo_o = all ones, div_zero = 1.
- Signed ops (MULT/DIV):
  - Operate on absolute values.
  - Record result signs: product/quotient is negative when operand signs differ; remainder takes the dividend's sign.
  - Apply the sign fix on entry to DONE.
  - The most-negative operand is handled by its absolute value treated as WIDTH-bit unsigned, so the result is exact modulo 2^(2*WIDTH).
- MUL: shift-add, one multiplier bit per cycle.
- DIV: restoring division, one quotient bit per cycle. Remainder is WIDTH+1 bits internally; hi_o = remainder, lo_o = quotient.
- Iteration: both MUL and DIV run exactly WIDTH cycles; when counter == 0, go to DONE.
- DONE: done = 1 for exactly one cycle; hi_o/lo_o/div_zero take the final results; next state IDLE.
- hi_o/lo_o change only on entry to DONE and hold otherwise.
- stallE (combinational):
  - stallE = (IDLE & startE & ~flushE & ~divzero_start) | MUL | DIV.
  - divzero_start is a divide with srcbE == 0.
  - stallE is 0 in DONE, so the stage advances in the same cycle done is seen.
- Latency (normal op):
  - Accept at cycle 0; MUL/DIV occupy cycles 1..WIDTH; DONE at cycle WIDTH+1.
  - stallE is high for cycles 0..WIDTH (WIDTH+1 cycles).
- Divide by zero: accept at cycle 0 with stallE = 0; DONE at cycle 1.
- No restart: startE still high in DONE does not start a new operation. A new start is accepted from IDLE only, earliest at cycle WIDTH+2.
- flushE in MUL/DIV: next state IDLE; hi_o/lo_o/div_zero unchanged; no done.
- flushE in DONE: no effect on done (the result is already committed).
- flushE with startE in IDLE: start ignored.
- Simultaneous rst and flushE/startE: rst wins.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined: MULT/MULTU skip the MUL state. A signed/unsigned 2*WIDTH combinational product is registered on the accept edge, and the unit goes directly to DONE. stallE is high in cycle 0 only; done at cycle 1.
- Undefined: iterative MUL as specified.
- Divide timing is identical in both builds.

Test Plan:
- MULT srcaE=0xFFFFFFFD (-3), srcbE=5, WIDTH=32 -> stallE high cycles 0..32, done at cycle 33, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Then DIVU 100/7 back-to-back after done -> lo_o=0x0000000E, hi_o=0x00000002.
- DIVU 5/0 -> stallE 0, done at cycle 1, div_zero=1, hi_o=5, lo_o=0xFFFFFFFF.
- Start MULT 3×4, assert flushE at cycle 10 -> state IDLE at cycle 11, no done, hi_o/lo_o keep previous values. Same stimulus with rst at cycle 10 -> all outputs 0.
- WIDTH=8: DIV 0x80/0xFF (-128/-1) -> done at cycle 9, lo_o=0x80, hi_o=0x00. With MULDIV_FAST_MUL_EN, MULT 3×4 -> done at cycle 1, lo_o=0x0C.
